// File: rtl/sym_stream_tx.sv
// sym_stream_tx: serializes a packed NSYM*SYMW-bit word into SYMW-bit symbols,
// symbol 0 first, with valid/last framing, hold back-pressure and a done pulse.
//
// Optional feature macro: SYM_TX_MIN_EN adds the exp_min running-minimum port.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   load    in   frame start request, sampled only while ready=1
//   data    in   packed frame, symbol k = data[k*SYMW +: SYMW]
//   hold    in   stall while sending
//   ready   out  idle and accepting load (combinational)
//   out     out  current symbol
//   valid   out  out carries a new symbol this cycle
//   last    out  final symbol of the frame (only with valid)
//   done    out  one-cycle frame-complete pulse
//   exp_min out  running minimum of symbols sent (SYM_TX_MIN_EN only)
module sym_stream_tx #(
   parameter int unsigned NSYM = 8,
   parameter int unsigned SYMW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [NSYM*SYMW-1:0] data,
   input  logic                 hold,
   output logic                 ready,
   output logic [SYMW-1:0]      out,
   output logic                 valid,
   output logic                 last,
   output logic                 done
`ifdef SYM_TX_MIN_EN
   ,
   output logic [SYMW-1:0]      exp_min
`endif
);

   localparam int unsigned DW = NSYM * SYMW;
   localparam int unsigned CW = $clog2(NSYM + 1);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_send = 2'd1,
      st_done = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [DW-1:0]   shift, shift_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [SYMW-1:0] out_n;
   logic            valid_n, last_n, done_n;
   logic [SYMW-1:0] sym;
   logic            final_sym;

   assign ready     = (state == st_idle);
   assign sym       = shift[SYMW-1:0];
   assign final_sym = (cnt == CW'(NSYM - 1));

`ifdef SYM_TX_MIN_EN
   logic [SYMW-1:0] min_q, min_n;
   assign exp_min = min_q;
`endif

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= st_idle;
         shift <= '0;
         cnt   <= '0;
         out   <= '0;
         valid <= 1'b0;
         last  <= 1'b0;
         done  <= 1'b0;
`ifdef SYM_TX_MIN_EN
         min_q <= '1;
`endif
      end else begin
         state <= state_n;
         shift <= shift_n;
         cnt   <= cnt_n;
         out   <= out_n;
         valid <= valid_n;
         last  <= last_n;
         done  <= done_n;
`ifdef SYM_TX_MIN_EN
         min_q <= min_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      shift_n = shift;
      cnt_n   = cnt;
      out_n   = out;
      valid_n = 1'b0;
      last_n  = 1'b0;
      done_n  = 1'b0;
`ifdef SYM_TX_MIN_EN
      min_n   = min_q;
`endif
      unique case (state)
         st_idle: begin
            if (load) begin
               shift_n = data;
               cnt_n   = '0;
               state_n = st_send;
`ifdef SYM_TX_MIN_EN
               min_n   = '1;
`endif
            end
         end
         st_send: begin
            // hold freezes out/shift/cnt; valid and last fall via defaults
            if (!hold) begin
               out_n   = sym;
               valid_n = 1'b1;
               last_n  = final_sym;
               shift_n = shift >> SYMW;
               cnt_n   = cnt + CW'(1);
`ifdef SYM_TX_MIN_EN
               if (sym < min_q) min_n = sym;
`endif
               if (final_sym) state_n = st_done;
            end
         end
         st_done: begin
            done_n  = 1'b1;
            state_n = st_idle;
         end
         default: state_n = st_idle;
      endcase
   end

endmodule

// File: tb/tb_sym_stream_tx.sv
// Directed bench for sym_stream_tx (NSYM=8, SYMW=2) with a symbol scoreboard.
module tb_sym_stream_tx;

   localparam int unsigned NSYM = 8;
   localparam int unsigned SYMW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 load;
   logic [NSYM*SYMW-1:0] data;
   logic                 hold;
   logic                 ready;
   logic [SYMW-1:0]      out;
   logic                 valid;
   logic                 last;
   logic                 done;
`ifdef SYM_TX_MIN_EN
   logic [SYMW-1:0]      exp_min;
`endif

   sym_stream_tx #(.NSYM(NSYM), .SYMW(SYMW)) dut (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .data  (data),
      .hold  (hold),
      .ready (ready),
      .out   (out),
      .valid (valid),
      .last  (last),
      .done  (done)
`ifdef SYM_TX_MIN_EN
      ,
      .exp_min (exp_min)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SYMW-1:0] sym;
      logic            lst;
   } exp_t;

   exp_t            sbq[$];
   int              n_assert = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              c0, fv, lv, dcyc, vcnt;
   bit              dseen;
   logic [SYMW-1:0] lastsym;
   logic [SYMW-1:0] emin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock; sample #1 after the edge and score any emitted symbol
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (valid === 1'b1) begin
         if (sbq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
         else begin
            e = sbq.pop_front();
            chk("out", 32'(out), 32'(e.sym));
            chk("last", 32'(last), 32'(e.lst));
            lastsym = e.sym;
         end
         if (vcnt == 0) fv = cyc;
         lv = cyc;
         vcnt++;
      end else begin
         chk("last_without_valid", 32'(last), 32'd0);
      end
      if (done === 1'b1) begin
         dseen = 1'b1;
         dcyc  = cyc;
      end
   endtask

   task automatic start_frame(input logic [NSYM*SYMW-1:0] d);
      exp_t e;
      logic [NSYM*SYMW-1:0] dv;
      dv   = d;
      emin = '1;
      for (int k = 0; k < int'(NSYM); k++) begin
         e.sym = dv[k*SYMW +: SYMW];
         e.lst = (k == int'(NSYM) - 1);
         if (e.sym < emin) emin = e.sym;
         sbq.push_back(e);
      end
      load  = 1'b1;
      data  = d;
      vcnt  = 0;
      dseen = 1'b0;
      tick();
      c0   = cyc;
      load = 1'b0;
      chk("ready_after_load", 32'(ready), 32'd0);
      chk("done_is_pulse", 32'(done), 32'd0);
      chk("valid_after_load", 32'(valid), 32'd0);
   endtask

   task automatic run_to_done(input int hold_at, input int hold_len, input int ign_at);
      int n;
      int hleft;
      n     = 0;
      hleft = hold_len;
      while (!dseen && n < 40) begin
         if (vcnt == hold_at && hleft > 0) begin
            hold = 1'b1;
            hleft--;
         end else hold = 1'b0;
         if (n == ign_at) begin
            load = 1'b1;
            data = '0;
         end else load = 1'b0;
         tick();
         if (hold) begin
            chk("stall_valid", 32'(valid), 32'd0);
            chk("stall_out", 32'(out), 32'(lastsym));
         end
         n++;
      end
      hold = 1'b0;
      load = 1'b0;
      if (!dseen) chk("done_timeout", 32'd0, 32'd1);
      else begin
         chk("done_latency", 32'(dcyc - c0), 32'(int'(NSYM) + 1 + hold_len));
         chk("valid_count", 32'(vcnt), 32'(NSYM));
         chk("valid_span", 32'(lv - fv), 32'(int'(NSYM) - 1 + hold_len));
         chk("first_valid_latency", 32'(fv - c0), 32'd1);
         chk("done_after_last", 32'(dcyc - lv), 32'd1);
         chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
         chk("ready_at_done", 32'(ready), 32'd1);
`ifdef SYM_TX_MIN_EN
         chk("exp_min_at_done", 32'(exp_min), 32'(emin));
`endif
      end
   endtask

   initial begin
      rst  = 1'b1;
      load = 1'b0;
      hold = 1'b0;
      data = '0;
      vcnt = 0;
      dseen = 1'b0;
      lastsym = '0;
      tick();
      tick();
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
`ifdef SYM_TX_MIN_EN
      chk("rst_exp_min", 32'(exp_min), 32'd3);
`endif
      rst = 1'b0;
      tick();

      // Basic frame
      start_frame(16'hEB15);
      run_to_done(-1, 0, -1);

      // Stall for two cycles after the third symbol
      tick();
      start_frame(16'hEB15);
      run_to_done(3, 2, -1);

      // Load during SEND is ignored
      tick();
      start_frame(16'h5A3C);
      run_to_done(-1, 0, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_second_frame", 32'(valid), 32'd0);
         chk("idle_ready", 32'(ready), 32'd1);
      end

      // Back-to-back: load in the done cycle
      start_frame(16'hEB15);
      run_to_done(-1, 0, -1);
      start_frame(16'hFFFF);
      run_to_done(-1, 0, -1);

      // Mid-frame asynchronous reset
      tick();
      start_frame(16'hEB15);
      for (int i = 0; i < 20 && vcnt < 4; i++) tick();
      chk("reached_4th_symbol", 32'(vcnt), 32'd4);
      rst = 1'b1;
      #1;
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_last", 32'(last), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_out", 32'(out), 32'd0);
`ifdef SYM_TX_MIN_EN
      chk("arst_exp_min", 32'(exp_min), 32'd3);
`endif
      sbq.delete();
      dseen = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk("no_done_after_abort", 32'(dseen), 32'd0);
      chk("ready_after_abort", 32'(ready), 32'd1);
      start_frame(16'hEB15);
      run_to_done(-1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sym_stream_tx.md
# sym_stream_tx

Symbol-stream transmitter that serializes a parallel word into a stream of SYMW-bit symbols, one symbol per accepted clock, with valid/last framing. It is the source end of the symbol interface consumed by the team's minimum-tracking FSM receivers. It loads a packed word through a ready/load handshake, supports back-pressure via `hold`, and signals frame completion with a `done` pulse. An optional running-minimum output gives benches the expected receiver result.

## Interface
- `NSYM`, default 8: symbols per frame, ≥2.
- `SYMW`, default 2: bits per symbol.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: frame start request, sampled only while `ready`=1.
- `data` input NSYM*SYMW: packed frame; symbol k = `data[k*SYMW +: SYMW]`, sent symbol 0 first.
- `hold` input 1: stall; while 1 in SEND, no symbol advances.
- `ready` output 1: block idle and accepting `load`.
- `out` output SYMW: current symbol.
- `valid` output 1: `out` carries a new symbol this cycle.
- `last` output 1: qualifies the final symbol of the frame; only high together with `valid`.
- `done` output 1: one-cycle frame-complete pulse.
- `exp_min` output SYMW: running minimum of symbols sent this frame. Present only with `SYM_TX_MIN_EN`.

## Operation
- States: IDLE, SEND, DONE. Reset state: IDLE.
- Internal registers: shift register (NSYM*SYMW bits), symbol counter (clog2(NSYM+1) bits), registered outputs.
- `ready` is combinational and equals (state==IDLE).
- IDLE, edge with `load`=1:
  - shift register <= `data`; counter <= 0; state <= SEND.
  - `valid` stays 0; `exp_min` <= all ones.
- IDLE, edge with `load`=0: no change. `data` is ignored outside IDLE.
- SEND, edge with `hold`=0:
  - `out` <= shift[SYMW-1:0]; `valid` <= 1; shift >>= SYMW; counter++.
  - `last` <= (counter==NSYM-1).
  - `exp_min` <= min(`exp_min`, symbol), unsigned compare.
  - If counter==NSYM-1: state <= DONE.
- SEND, edge with `hold`=1:
  - `valid` <= 0; `last` <= 0.
  - `out`, counter and shift register hold their values.
- DONE, next edge: `valid` <= 0; `last` <= 0; `done` <= 1; state <= IDLE.
- `done` is 0 on every other edge.
- `load` is ignored in SEND and DONE, with no queueing.
- `load` may be asserted in the cycle `done` is high, because `ready` is already 1 then. The new frame starts without loss.
- Reset at any time, including mid-frame: state IDLE, frame aborted, no `done`.

## Timing
- Reset values: `ready`=1, `out`=0, `valid`=0, `last`=0, `done`=0, `exp_min`=all ones.
- Load latency: the edge that samples `load` moves to SEND. Symbol 0 is valid after the next edge with `hold`=0. Minimum load-to-first-valid is 2 edges.
- Throughput: 1 symbol per cycle with `hold`=0. A frame with no stalls takes NSYM+2 cycles from `load` sampled to `done` high.
- `hold` adds exactly one cycle per asserted SEND cycle. `hold` in IDLE or DONE has no effect.
- `exp_min` is final and stable while `done`=1. It holds until the next `load` is sampled.

## Configuration
- `SYM_TX_MIN_EN` defined:
  - `exp_min` port and min-tracking logic are present, behaving as above.
- `SYM_TX_MIN_EN` undefined:
  - The `exp_min` port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use NSYM=8, SYMW=2.
- Reset: `rst` high mid-run → `ready`=1, `valid`=0, `last`=0, `done`=0, `out`=0, `exp_min`=3, immediately (asynchronous).
- Basic frame, `data`=16'hEB15, `hold`=0 → `out` sequence 1,1,1,0,3,2,2,3 on 8 consecutive `valid` cycles; `last` high only with the final 3; `done` 1 cycle later; `exp_min`=0.
- Stall: same frame, `hold`=1 for 2 cycles after the 3rd symbol → `valid`=0 for exactly 2 cycles, `out` held at 1; sequence unchanged; `done` 2 cycles later than the basic frame.
- Ignored load: `load`=1 with `data`=16'h0000 during SEND → current frame unaffected; no second frame starts.
- Back-to-back: `load` asserted in the `done` cycle with `data`=16'hFFFF → new frame of eight 3s; `exp_min`=3 at its `done`.
- Mid-frame reset: `rst` pulsed after the 4th symbol → no `done`, `ready`=1; next load of 16'hEB15 sends the full correct sequence.
